sprw_issue_ctrl: RTL and testbench

Issue controller and two-port arbiter for the SPARROW SIMD pipeline (`sprw_wrapper`). It accepts operand/instruction requests from two requesters over valid/ready handshakes and picks one per cycle with round-robin priority. It tracks each issued op through the fixed-latency pipeline with a tag shift register and returns results on a single valid/ready response port. Back-pressure on the response port freezes the pipeline through `holdn`, so no result is ever dropped.

---
 rtl/sprw_issue_ctrl_pkg.sv | 14 +
 rtl/sprw_issue_ctrl_if.sv | 31 +++
 rtl/sprw_issue_ctrl_rr_arb2.sv | 31 +++
 rtl/sprw_issue_ctrl.sv | 91 +++++++++
 tb/tb_sprw_issue_ctrl.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/sprw_issue_ctrl_pkg.sv
// Shared SPARROW definitions: pipeline depth and the
// per-stage tag record carried alongside the SIMD pipe.
package sparrow;

   localparam int SPRW_LAT  = 2;
   localparam int SPRW_TAGW = 4;

   typedef struct packed {
      logic                 v;
      logic                 src;
      logic [SPRW_TAGW-1:0] tag;
   } sprw_tag_t;

endpackage

// File: rtl/sprw_issue_ctrl_if.sv
// Request/response handshake bundle between the two
// requesters, the response consumer and the issue controller.
interface sprw_issue_ctrl_if #(
   parameter int TAGW = 4
);
   logic [1:0]           req_valid;
   logic [1:0]           req_ready;
   logic [1:0][31:0]     req_ra;
   logic [1:0][31:0]     req_rb;
   logic [1:0][31:0]     req_instr;
   logic [1:0][TAGW-1:0] req_tag;
   logic                 rsp_valid;
   logic                 rsp_ready;
   logic [31:0]          rsp_data;
   logic                 rsp_src;
   logic [TAGW-1:0]      rsp_tag;

   modport master (
      output req_valid, req_ra, req_rb,
      output req_instr, req_tag, rsp_ready,
      input  req_ready, rsp_valid, rsp_data,
      input  rsp_src, rsp_tag
   );

   modport slave (
      input  req_valid, req_ra, req_rb,
      input  req_instr, req_tag, rsp_ready,
      output req_ready, rsp_valid, rsp_data,
      output rsp_src, rsp_tag
   );
endinterface

// File: rtl/sprw_issue_ctrl_rr_arb2.sv
// Two-input round-robin arbiter; the pointer names the
// requester that wins the next tie.
module sprw_rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [1:0] valid,
   output logic [1:0] grant,
   output logic       winner
);
   logic rr_ptr;

   always_comb begin
      winner = 1'b0;
      grant  = 2'b00;
      unique case (1'b1)
         (valid == 2'b11): winner = rr_ptr;
         (valid == 2'b10): winner = 1'b1;
         default:          winner = 1'b0;
      endcase
      if (en && (valid != 2'b00))
         grant = winner ? 2'b10 : 2'b01;
   end

   always_ff @(posedge clk) begin
      if (rst)
         rr_ptr <= 1'b0;
      else if (|grant)
         rr_ptr <= ~winner;
   end
endmodule

// File: rtl/sprw_issue_ctrl.sv
// Issue controller for the SPARROW pipe: arbitrates two
// requesters and tracks each op with a lockstep tag pipe.
module sprw_issue_ctrl
   import sparrow::*;
#(
   parameter int LAT  = SPRW_LAT,
   parameter int TAGW = SPRW_TAGW
) (
   input  logic              clk,
   input  logic              rst,
   sprw_issue_ctrl_if.slave  bus,
   output logic              sprw_rstn,
   output logic              sprw_holdn,
   output logic [31:0]       sprw_ra,
   output logic [31:0]       sprw_rb,
   output logic [31:0]       sprw_instr,
   input  logic [31:0]       sprw_out,
   output logic [2:0]        inflight,
   output logic [31:0]       issue_cnt
);
   sprw_tag_t   pipe_q [LAT];
   sprw_tag_t   stage_in;
   logic [1:0]  grant;
   logic        winner;
   logic [31:0] issue_cnt_q;
   logic [2:0]  n_valid;

   assign sprw_rstn = ~rst;

   // Stall only when a result is waiting unconsumed.
   assign sprw_holdn = rst |
      ~(bus.rsp_valid & ~bus.rsp_ready);

   sprw_rr_arb2 u_arb (
      .clk    (clk),
      .rst    (rst),
      .en     (sprw_holdn & ~rst),
      .valid  (bus.req_valid),
      .grant  (grant),
      .winner (winner)
   );

   assign bus.req_ready = grant;

   always_comb begin
      stage_in   = '0;
      sprw_ra    = '0;
      sprw_rb    = '0;
      sprw_instr = '0;
      if (|grant) begin
         stage_in.v   = 1'b1;
         stage_in.src = winner;
         stage_in.tag =
            SPRW_TAGW'(bus.req_tag[winner]);
         sprw_ra      = bus.req_ra[winner];
         sprw_rb      = bus.req_rb[winner];
         sprw_instr   = bus.req_instr[winner];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < LAT; k++)
            pipe_q[k] <= '0;
      end else if (sprw_holdn) begin
         pipe_q[0] <= stage_in;
         for (int k = 1; k < LAT; k++)
            pipe_q[k] <= pipe_q[k-1];
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         issue_cnt_q <= '0;
      else if (|grant)
         issue_cnt_q <= issue_cnt_q + 32'd1;
   end

   always_comb begin
      n_valid = '0;
      for (int k = 0; k < LAT; k++)
         n_valid = n_valid + {2'b00, pipe_q[k].v};
   end

   assign inflight      = n_valid;
   assign issue_cnt     = issue_cnt_q;
   assign bus.rsp_valid = pipe_q[LAT-1].v;
   assign bus.rsp_src   = pipe_q[LAT-1].src;
   assign bus.rsp_tag   = TAGW'(pipe_q[LAT-1].tag);
   assign bus.rsp_data  = sprw_out;
endmodule

// File: tb/tb_sprw_issue_ctrl.sv
// Directed bench for sprw_issue_ctrl with a small
// behavioural stand-in for the SPARROW pipe.
module tb_sprw_issue_ctrl;
   import sparrow::*;

   localparam int LAT = SPRW_LAT;

   typedef struct {
      logic [1:0] v;
      logic [3:0] t0;
      logic [3:0] t1;
      logic [1:0] rdy;
      logic       rv;
      logic       src;
      logic [3:0] tag;
      logic [2:0] infl;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        sprw_rstn, sprw_holdn;
   logic [31:0] sprw_ra, sprw_rb, sprw_instr;
   logic [31:0] sprw_out;
   logic [2:0]  inflight;
   logic [31:0] issue_cnt;
   logic [31:0] mp [LAT];

   int n_chk = 0;
   int n_fail = 0;

   sprw_issue_ctrl_if #(.TAGW(4)) bus ();

   sprw_issue_ctrl #(.LAT(LAT), .TAGW(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .sprw_rstn  (sprw_rstn),
      .sprw_holdn (sprw_holdn),
      .sprw_ra    (sprw_ra),
      .sprw_rb    (sprw_rb),
      .sprw_instr (sprw_instr),
      .sprw_out   (sprw_out),
      .inflight   (inflight),
      .issue_cnt  (issue_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] sfun(
      input logic [31:0] a, b, i);
      return (a + b) ^ i;
   endfunction

   function automatic logic [31:0] opa(
      input logic s, input logic [3:0] t);
      return (s ? 32'h100 : 32'h0) + 32'(t) - 32'd2;
   endfunction

   function automatic logic [31:0] opi(
      input logic s, input logic [3:0] t);
      return 32'h8000_0000 | (s ? 32'h10 : 32'h0)
         | 32'(t);
   endfunction

   function automatic logic [31:0] expd(
      input logic s, input logic [3:0] t);
      return sfun(opa(s, t), 32'd4, opi(s, t));
   endfunction

   // Reference SPARROW: LAT-deep frozen-on-hold pipe.
   always_ff @(posedge clk) begin
      if (!sprw_rstn) begin
         for (int k = 0; k < LAT; k++) mp[k] <= '0;
      end else if (sprw_holdn) begin
         mp[0] <= sfun(sprw_ra, sprw_rb, sprw_instr);
         for (int k = 1; k < LAT; k++)
            mp[k] <= mp[k-1];
      end
   end
   assign sprw_out = mp[LAT-1];

   task automatic chk(input string nm,
      input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h",
            nm, act, exp);
      end
   endtask

   task automatic drive(input logic [1:0] v,
      input logic [3:0] t0, input logic [3:0] t1);
      bus.req_valid    = v;
      bus.req_tag[0]   = t0;
      bus.req_tag[1]   = t1;
      bus.req_ra[0]    = opa(1'b0, t0);
      bus.req_ra[1]    = opa(1'b1, t1);
      bus.req_rb[0]    = 32'd4;
      bus.req_rb[1]    = 32'd4;
      bus.req_instr[0] = opi(1'b0, t0);
      bus.req_instr[1] = opi(1'b1, t1);
   endtask

   vec_t tbl [20];

   initial begin
      int nxt, rcv, stalls;
      logic [31:0] held_d;
      logic [3:0]  held_t;
      logic        w;
      logic [3:0]  wt;

      tbl[0]  = '{2'b01, 4'd5, 4'd0, 2'b01, 0, 0, 4'd0, 3'd0};
      tbl[1]  = '{2'b00, 4'd0, 4'd0, 2'b00, 0, 0, 4'd0, 3'd1};
      tbl[2]  = '{2'b00, 4'd0, 4'd0, 2'b00, 1, 0, 4'd5, 3'd1};
      tbl[3]  = '{2'b10, 4'd0, 4'd7, 2'b10, 0, 0, 4'd0, 3'd0};
      tbl[4]  = '{2'b11, 4'd1, 4'd8, 2'b01, 0, 0, 4'd0, 3'd1};
      tbl[5]  = '{2'b11, 4'd2, 4'd8, 2'b10, 1, 1, 4'd7, 3'd2};
      tbl[6]  = '{2'b11, 4'd2, 4'd9, 2'b01, 1, 0, 4'd1, 3'd2};
      tbl[7]  = '{2'b11, 4'd3, 4'd9, 2'b10, 1, 1, 4'd8, 3'd2};
      tbl[8]  = '{2'b11, 4'd3, 4'd10, 2'b01, 1, 0, 4'd2, 3'd2};
      tbl[9]  = '{2'b11, 4'd4, 4'd10, 2'b10, 1, 1, 4'd9, 3'd2};
      tbl[10] = '{2'b00, 4'd0, 4'd0, 2'b00, 1, 0, 4'd3, 3'd2};
      tbl[11] = '{2'b00, 4'd0, 4'd0, 2'b00, 1, 1, 4'd10, 3'd1};
      tbl[12] = '{2'b00, 4'd0, 4'd0, 2'b00, 0, 0, 4'd0, 3'd0};
      tbl[13] = '{2'b01, 4'd4, 4'd0, 2'b01, 0, 0, 4'd0, 3'd0};
      tbl[14] = '{2'b00, 4'd0, 4'd0, 2'b00, 0, 0, 4'd0, 3'd1};
      tbl[15] = '{2'b00, 4'd0, 4'd0, 2'b00, 1, 0, 4'd4, 3'd1};
      tbl[16] = '{2'b10, 4'd0, 4'd6, 2'b10, 0, 0, 4'd0, 3'd0};
      tbl[17] = '{2'b00, 4'd0, 4'd0, 2'b00, 0, 0, 4'd0, 3'd1};
      tbl[18] = '{2'b00, 4'd0, 4'd0, 2'b00, 1, 1, 4'd6, 3'd1};
      tbl[19] = '{2'b00, 4'd0, 4'd0, 2'b00, 0, 0, 4'd0, 3'd0};

      drive(2'b11, 4'd1, 4'd2);
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      #1;
      chk("rst_ready", 64'(bus.req_ready), 64'd0);
      chk("rst_rstn", 64'(sprw_rstn), 64'd0);
      chk("rst_holdn", 64'(sprw_holdn), 64'd1);
      chk("rst_ra", 64'(sprw_ra), 64'd0);
      chk("rst_instr", 64'(sprw_instr), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      drive(2'b00, 4'd0, 4'd0);
      #1;
      chk("rst_rvalid", 64'(bus.rsp_valid), 64'd0);
      chk("rst_infl", 64'(inflight), 64'd0);
      chk("rst_cnt", 64'(issue_cnt), 64'd0);
      chk("rst_rstn_rel", 64'(sprw_rstn), 64'd1);

      // Single op, tie-break flip, contention, bubbles.
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         drive(tbl[i].v, tbl[i].t0, tbl[i].t1);
         #1;
         w  = tbl[i].rdy[1];
         wt = w ? tbl[i].t1 : tbl[i].t0;
         chk($sformatf("v%0d_ready", i),
            64'(bus.req_ready), 64'(tbl[i].rdy));
         chk($sformatf("v%0d_holdn", i),
            64'(sprw_holdn), 64'd1);
         chk($sformatf("v%0d_rvalid", i),
            64'(bus.rsp_valid), 64'(tbl[i].rv));
         chk($sformatf("v%0d_infl", i),
            64'(inflight), 64'(tbl[i].infl));
         chk($sformatf("v%0d_instr", i),
            64'(sprw_instr),
            (tbl[i].rdy != 0) ? 64'(opi(w, wt)) : 64'd0);
         chk($sformatf("v%0d_ra", i), 64'(sprw_ra),
            (tbl[i].rdy != 0) ? 64'(opa(w, wt)) : 64'd0);
         if (tbl[i].rv) begin
            chk($sformatf("v%0d_src", i),
               64'(bus.rsp_src), 64'(tbl[i].src));
            chk($sformatf("v%0d_tag", i),
               64'(bus.rsp_tag), 64'(tbl[i].tag));
            chk($sformatf("v%0d_data", i),
               64'(bus.rsp_data),
               64'(expd(tbl[i].src, tbl[i].tag)));
         end
      end
      @(negedge clk);
      drive(2'b00, 4'd0, 4'd0);
      #1;
      chk("tbl_issue_cnt", 64'(issue_cnt), 64'd10);

      // Back-pressure: requester 1 streams 4 ops.
      nxt = 1;
      rcv = 0;
      stalls = 0;
      for (int c = 0; c < 30 && rcv < 4; c++) begin
         @(negedge clk);
         drive((nxt <= 4) ? 2'b10 : 2'b00,
            4'd0, 4'(nxt));
         bus.rsp_ready = !(bus.rsp_valid && stalls < 3);
         #1;
         if (bus.rsp_valid && !bus.rsp_ready) begin
            stalls++;
            chk("bp_holdn", 64'(sprw_holdn), 64'd0);
            chk("bp_ready", 64'(bus.req_ready), 64'd0);
            if (stalls == 1) begin
               held_d = bus.rsp_data;
               held_t = bus.rsp_tag;
            end else begin
               chk("bp_data_hold",
                  64'(bus.rsp_data), 64'(held_d));
               chk("bp_tag_hold",
                  64'(bus.rsp_tag), 64'(held_t));
            end
         end
         if (bus.rsp_valid && bus.rsp_ready) begin
            rcv++;
            chk("bp_tag", 64'(bus.rsp_tag), 64'(rcv));
            chk("bp_src", 64'(bus.rsp_src), 64'd1);
            chk("bp_data", 64'(bus.rsp_data),
               64'(expd(1'b1, 4'(rcv))));
         end
         chk("bp_infl_max", 64'(inflight <= 3'(LAT)),
            64'd1);
         if (bus.req_ready[1]) nxt++;
      end
      chk("bp_received", 64'(rcv), 64'd4);
      chk("bp_stalls", 64'(stalls), 64'd3);
      chk("bp_issued", 64'(nxt), 64'd5);

      // Reset while an op is in flight.
      @(negedge clk);
      bus.rsp_ready = 1'b1;
      drive(2'b01, 4'd2, 4'd0);
      #1;
      chk("mr_ready0", 64'(bus.req_ready), 64'd1);
      @(negedge clk);
      rst = 1'b1;
      drive(2'b11, 4'd3, 4'd3);
      #1;
      chk("mr_ready_rst", 64'(bus.req_ready), 64'd0);
      chk("mr_rstn", 64'(sprw_rstn), 64'd0);
      chk("mr_instr", 64'(sprw_instr), 64'd0);
      chk("mr_holdn", 64'(sprw_holdn), 64'd1);
      @(negedge clk);
      rst = 1'b0;
      drive(2'b00, 4'd0, 4'd0);
      #1;
      chk("mr_infl", 64'(inflight), 64'd0);
      chk("mr_cnt", 64'(issue_cnt), 64'd0);
      for (int c = 0; c < 4; c++) begin
         chk($sformatf("mr_norsp%0d", c),
            64'(bus.rsp_valid), 64'd0);
         @(negedge clk);
         #1;
      end

      // Counter wrap.
      force dut.issue_cnt_q = 32'hFFFF_FFFF;
      @(negedge clk);
      release dut.issue_cnt_q;
      #1;
      chk("wrap_pre", 64'(issue_cnt), 64'hFFFF_FFFF);
      drive(2'b01, 4'd1, 4'd0);
      #1;
      chk("wrap_ready", 64'(bus.req_ready), 64'd1);
      @(negedge clk);
      drive(2'b00, 4'd0, 4'd0);
      #1;
      chk("wrap_cnt", 64'(issue_cnt), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
         n_chk, n_fail);
      $finish;
   end
endmodule
